// File: rtl/video_pkg.sv
// Shared timing defaults, coordinate widths and the {block, pixel} pair type
// for the raster timing / scroll coordinate generator.
package video_pkg;

  localparam int H_TOTAL_DEF        = 1024;
  localparam int H_SYNC_START_DEF   = 64;
  localparam int H_SYNC_END_DEF     = 136;
  localparam int H_ACTIVE_START_DEF = 304;
  localparam int V_TOTAL_DEF        = 625;
  localparam int V_ACTIVE_DEF       = 540;
  localparam int V_SYNC_START_DEF   = 571;
  localparam int V_SYNC_END_DEF     = 573;
  localparam int PIX_PER_BLOCK_DEF  = 12;
  localparam int X_BLOCKS_DEF       = 64;
  localparam int Y_BLOCKS_DEF       = 48;

  localparam int BLOCK_W = 6;
  localparam int PIX_W   = 4;

  typedef struct packed {
    logic [BLOCK_W-1:0] blk;
    logic [PIX_W-1:0]   pix;
  } coord_t;

  // Normalise a raw scroll value: block reduced modulo nblk, pixel clamped.
  function automatic coord_t norm_coord(input logic [BLOCK_W-1:0] blk,
                                        input logic [PIX_W-1:0]   pix,
                                        input int                 ppb,
                                        input int                 nblk);
    coord_t c;
    c.blk = BLOCK_W'(32'(blk) % 32'(nblk));
    c.pix = (32'(pix) >= 32'(ppb)) ? PIX_W'(ppb - 1) : pix;
    return c;
  endfunction

endpackage

// File: rtl/block_pos_counter.sv
// Loadable block/pixel position counter: pixel wraps at PIX_PER_BLOCK and
// carries into a block field that wraps at MODULUS.
module block_pos_counter
  import video_pkg::*;
#(
  parameter int PIX_PER_BLOCK = PIX_PER_BLOCK_DEF,
  parameter int MODULUS       = X_BLOCKS_DEF
) (
  input  logic   clk,
  input  logic   rst,
  input  logic   load_i,
  input  coord_t load_val_i,
  input  logic   adv_i,
  output coord_t pos_o
);

  coord_t pos_q, pos_d;

  always_comb begin
    pos_d = pos_q;
    if (load_i) begin
      pos_d = load_val_i;
    end else if (adv_i) begin
      if (pos_q.pix == PIX_W'(PIX_PER_BLOCK - 1)) begin
        pos_d.pix = '0;
        pos_d.blk = (pos_q.blk == BLOCK_W'(MODULUS - 1)) ? '0
                                                           : pos_q.blk + BLOCK_W'(1);
      end else begin
        pos_d.pix = pos_q.pix + PIX_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) pos_q <= '0;
    else      pos_q <= pos_d;
  end

  assign pos_o = pos_q;

endmodule

// File: rtl/video_timing_scroll.sv
// Raster timing with frame-synchronous X/Y scroll and block/pixel coordinates.
// Optional raster compare interrupt under macro VIDEO_RASTER_IRQ_EN.
module video_timing_scroll
  import video_pkg::*;
#(
  parameter int H_TOTAL        = H_TOTAL_DEF,
  parameter int H_SYNC_START   = H_SYNC_START_DEF,
  parameter int H_SYNC_END     = H_SYNC_END_DEF,
  parameter int H_ACTIVE_START = H_ACTIVE_START_DEF,
  parameter int V_TOTAL        = V_TOTAL_DEF,
  parameter int V_ACTIVE       = V_ACTIVE_DEF,
  parameter int V_SYNC_START   = V_SYNC_START_DEF,
  parameter int V_SYNC_END     = V_SYNC_END_DEF,
  parameter int PIX_PER_BLOCK  = PIX_PER_BLOCK_DEF,
  parameter int X_BLOCKS       = X_BLOCKS_DEF,
  parameter int Y_BLOCKS       = Y_BLOCKS_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               scroll_wr,
  input  logic [BLOCK_W-1:0] scroll_x_block,
  input  logic [PIX_W-1:0]   scroll_x_pixel,
  input  logic [BLOCK_W-1:0] scroll_y_block,
  input  logic [PIX_W-1:0]   scroll_y_pixel,
  input  logic [9:0]         raster_line,
  output logic [9:0]         vga_x,
  output logic [9:0]         vga_y,
  output logic               hsync,
  output logic               vsync,
  output logic               active,
  output logic [BLOCK_W-1:0] x_block,
  output logic [PIX_W-1:0]   x_pixel,
  output logic [BLOCK_W-1:0] y_block,
  output logic [PIX_W-1:0]   y_pixel,
  output logic               line_start,
  output logic               frame_start,
  output logic               raster_irq
);

  logic [9:0] x_q, x_d, y_q, y_d;
  logic       hsync_q, hsync_d, vsync_q, vsync_d, active_q, active_d;
  logic       ls_q, ls_d, fs_q, fs_d, irq_q, irq_d;
  coord_t     stg_x_q, stg_x_d, stg_y_q, stg_y_d;
  coord_t     shd_x_q, shd_x_d, shd_y_q, shd_y_d;
  coord_t     xpos, ypos;
  logic       x_wrap, y_wrap, frame_wrap;

  assign x_wrap     = (x_q == 10'(H_TOTAL - 1));
  assign y_wrap     = (y_q == 10'(V_TOTAL - 1));
  assign frame_wrap = x_wrap && y_wrap;

  // Every output register is computed from the next raster position so all
  // outputs describe the same (vga_x, vga_y) in a given cycle.
  always_comb begin
    x_d      = x_wrap ? '0 : x_q + 10'd1;
    y_d      = x_wrap ? (y_wrap ? '0 : y_q + 10'd1) : y_q;
    hsync_d  = (x_d >= 10'(H_SYNC_START)) && (x_d < 10'(H_SYNC_END));
    vsync_d  = (x_d == 10'(H_SYNC_START))
               ? ((y_d >= 10'(V_SYNC_START)) && (y_d < 10'(V_SYNC_END)))
               : vsync_q;
    active_d = (x_d >= 10'(H_ACTIVE_START)) && (y_d < 10'(V_ACTIVE));
    ls_d     = (x_d == '0);
    fs_d     = (x_d == '0) && (y_d == '0);
    stg_x_d  = scroll_wr ? norm_coord(scroll_x_block, scroll_x_pixel, PIX_PER_BLOCK, X_BLOCKS)
                         : stg_x_q;
    stg_y_d  = scroll_wr ? norm_coord(scroll_y_block, scroll_y_pixel, PIX_PER_BLOCK, Y_BLOCKS)
                         : stg_y_q;
    // Shadow takes the pre-write staging value on the frame-wrap clock.
    shd_x_d  = frame_wrap ? stg_x_q : shd_x_q;
    shd_y_d  = frame_wrap ? stg_y_q : shd_y_q;
  end

`ifdef VIDEO_RASTER_IRQ_EN
  assign irq_d = (x_d == '0) && (y_d == raster_line);
`else
  logic unused_raster;
  assign unused_raster = ^raster_line;
  assign irq_d         = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!rst) begin
      x_q      <= '0;
      y_q      <= '0;
      hsync_q  <= 1'b0;
      vsync_q  <= 1'b0;
      active_q <= 1'b0;
      ls_q     <= 1'b0;
      fs_q     <= 1'b0;
      irq_q    <= 1'b0;
      stg_x_q  <= '0;
      stg_y_q  <= '0;
      shd_x_q  <= '0;
      shd_y_q  <= '0;
    end else begin
      x_q      <= x_d;
      y_q      <= y_d;
      hsync_q  <= hsync_d;
      vsync_q  <= vsync_d;
      active_q <= active_d;
      ls_q     <= ls_d;
      fs_q     <= fs_d;
      irq_q    <= irq_d;
      stg_x_q  <= stg_x_d;
      stg_y_q  <= stg_y_d;
      shd_x_q  <= shd_x_d;
      shd_y_q  <= shd_y_d;
    end
  end

  // X restarts from the shadow at the first visible clock and holds in blanking.
  block_pos_counter #(
    .PIX_PER_BLOCK(PIX_PER_BLOCK),
    .MODULUS      (X_BLOCKS)
  ) u_xpos (
    .clk       (clk),
    .rst       (rst),
    .load_i    (active_d && (x_d == 10'(H_ACTIVE_START))),
    .load_val_i(shd_x_q),
    .adv_i     (active_d && (x_d != 10'(H_ACTIVE_START))),
    .pos_o     (xpos)
  );

  // Y loads the value entering the shadow so line 0 is valid at frame_start.
  block_pos_counter #(
    .PIX_PER_BLOCK(PIX_PER_BLOCK),
    .MODULUS      (Y_BLOCKS)
  ) u_ypos (
    .clk       (clk),
    .rst       (rst),
    .load_i    (frame_wrap),
    .load_val_i(stg_y_q),
    .adv_i     (x_wrap && !y_wrap),
    .pos_o     (ypos)
  );

  assign vga_x       = x_q;
  assign vga_y       = y_q;
  assign hsync       = hsync_q;
  assign vsync       = vsync_q;
  assign active      = active_q;
  assign x_block     = xpos.blk;
  assign x_pixel     = xpos.pix;
  assign y_block     = ypos.blk;
  assign y_pixel     = ypos.pix;
  assign line_start  = ls_q;
  assign frame_start = fs_q;
  assign raster_irq  = irq_q;

endmodule
